mips_trace_buffer: RTL and testbench
====================================

MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning trace entries held, power of two, min 4.
REQ-002 The module SHALL have parameter PC_W, default 11, meaning width of the captured PC field.
REQ-003 The module SHALL have parameter POST_TRIG, default 32, meaning records captured after the trigger, range 0..DEPTH-1.
REQ-004 The module SHALL have parameter REC_W, derived as PC_W+32+1+32+32+1+5+32, meaning the trace record width.
REQ-005 clk  in  1  sole clock; every state element updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  CPU pipeline advance; records are taken only on cycles with en=1.
REQ-008 dec_pc  in  PC_W  decode-stage PC.
REQ-009 dec_instr  in  32  decode-stage instruction word.
REQ-010 mem_we / mem_addr / mem_wdata  in  1/32/32  memory-stage store event.
REQ-011 reg_we / reg_waddr / reg_wdata  in  1/5/32  writeback-stage register write.
REQ-012 mode  in  2  capture mode: 0 wrap+trigger, 1 stop-on-full, 2 writes-only wrap+trigger, 3 reserved (behaves as 1).
REQ-013 arm / abort  in  1/1  single-cycle pulses that start or cancel a capture.
REQ-014 trig_en / trig_pc  in  1/PC_W  PC-match trigger enable and compare value.
REQ-015 rd_valid  out  1  oldest stored record available.
REQ-016 rd_ready  in  1  consumer accepts the record.
REQ-017 rd_data  out  REC_W  {pc, instr, mem_we, mem_addr, mem_wdata, reg_we_eff, reg_waddr, reg_wdata}, MSB first.
REQ-018 busy / done / triggered / wrapped  out  1 each  status flags.
REQ-019 count  out  log2(DEPTH)+1  number of stored records.

Function
REQ-020 The FSM SHALL have states IDLE, CAPTURE, POST and DRAIN.
REQ-021 In IDLE, arm=1 SHALL enter CAPTURE next cycle, clearing wr_ptr, count, triggered and wrapped.
REQ-022 A record SHALL be written in CAPTURE or POST when en=1 and the entry qualifies; in mode 2 an entry qualifies only if mem_we=1 or reg_we_eff=1, in other modes always.
REQ-023 reg_we_eff SHALL equal reg_we AND (reg_waddr != 0); register-0 writes are never flagged.
REQ-024 Each write SHALL store at wr_ptr and increment wr_ptr modulo DEPTH; count SHALL increment and saturate at DEPTH.
REQ-025 In modes 0 and 2, a write with count=DEPTH SHALL overwrite the oldest entry and set wrapped=1 (sticky until the next arm).
REQ-026 In modes 0 and 2, a qualifying write with trig_en=1 and dec_pc==trig_pc SHALL set triggered=1, load post_cnt=POST_TRIG, and enter POST; with POST_TRIG=0 it SHALL enter DRAIN instead; the trigger record itself is stored.
REQ-027 In POST, each write SHALL decrement post_cnt; the write that makes post_cnt 0 SHALL enter DRAIN next cycle; further trigger matches SHALL be ignored.
REQ-028 In modes 1 and 3, the write that makes count=DEPTH SHALL enter DRAIN next cycle; the trigger is ignored.
REQ-029 In DRAIN, rd_valid SHALL be 1 iff count>0; rd_data SHALL be the entry at (wr_ptr-count) mod DEPTH, combinational from the storage array.
REQ-030 A pop SHALL occur on rd_valid AND rd_ready and decrement count; the next-oldest record SHALL appear the following cycle.
REQ-031 DRAIN with count=0 SHALL return to IDLE next cycle; entering DRAIN with count=0 SHALL also return to IDLE.
REQ-032 rd_valid SHALL be 0 outside DRAIN; rd_ready SHALL be ignored outside DRAIN.
REQ-033 busy SHALL be 1 in CAPTURE and POST; done SHALL be 1 in DRAIN.
REQ-034 arm SHALL be ignored outside IDLE; abort in any state SHALL return to IDLE next cycle with count=0; when arm and abort coincide, abort SHALL win.
REQ-035 en=0 cycles SHALL cause no write, no trigger, and no post_cnt change.

Reset
REQ-036 rst SHALL force IDLE, wr_ptr=0, count=0, post_cnt=0, and busy, done, triggered, wrapped, rd_valid all 0, taking priority over all inputs including in mid-capture or mid-drain.
REQ-037 Storage array contents SHALL not be reset and are unobservable until rewritten.

Verification
REQ-038 DEPTH=8, mode 1, arm, then 8 cycles en=1 with dec_pc=0..7 -> DRAIN, count=8, pops return pc 0..7 in order, then IDLE.
REQ-039 DEPTH=8, POST_TRIG=4, mode 0, trig_pc=20, pcs 0..30 step 1 -> triggered=1, wrapped=1, drained pcs are 17..24 (8 records).
REQ-040 mode 2: 10 entries with only pcs 3 and 7 carrying mem_we=1 and pc 5 carrying reg_we with reg_waddr=0 -> count=2, records pc 3 and 7 only.
REQ-041 DRAIN with rd_ready toggling 1,0,1,0 -> exactly one pop per rd_ready=1 cycle, rd_data is stable while rd_ready=0.
REQ-042 rst asserted in POST with count=5 -> next cycle IDLE, count=0, all flags 0; a subsequent arm restarts cleanly.
REQ-043 arm and abort in the same cycle during CAPTURE -> IDLE, count=0; en=0 for 3 cycles mid-CAPTURE -> count unchanged.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: captures MIPS pipeline trace records into a circular buffer and drains them oldest-first.
// Latency: a record is stored on the clock edge of its en cycle; rd_data is combinational from storage.
// Backpressure: valid/ready pop during DRAIN only; capture never stalls the CPU (old entries overwrite in wrap modes).
module mips_trace_buffer #(
  parameter int DEPTH     = 64,
  parameter int PC_W      = 11,
  parameter int POST_TRIG = 32,
  parameter int REC_W     = PC_W + 32 + 1 + 32 + 32 + 1 + 5 + 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PC_W-1:0]          dec_pc,
  input  logic [31:0]              dec_instr,
  input  logic                     mem_we,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic                     reg_we,
  input  logic [4:0]               reg_waddr,
  input  logic [31:0]              reg_wdata,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [REC_W-1:0]         rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     triggered,
  output logic                     wrapped,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LAST      = FULL - CNT_ONE;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {IDLE, CAPTURE, POST, DRAIN} state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    post_cnt;
  logic [AW-1:0]    rd_addr;
  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] record;

  logic reg_we_eff;
  logic wrap_mode;
  logic qualifies;
  logic trig_hit;
  logic capturing;
  logic do_write;

  // Writes to $zero never change architectural state, so they are not flagged.
  assign reg_we_eff = reg_we && (reg_waddr != 5'd0);
  // Modes 0 and 2 wrap and honour the trigger; 1 and the reserved 3 stop when full.
  assign wrap_mode  = (mode == 2'd0) || (mode == 2'd2);
  assign qualifies  = (mode == 2'd2) ? (mem_we || reg_we_eff) : 1'b1;
  assign trig_hit   = trig_en && (dec_pc == trig_pc);
  assign capturing  = (state == CAPTURE) || (state == POST);
  assign do_write   = capturing && en && qualifies;

  assign record = {dec_pc, dec_instr, mem_we, mem_addr, mem_wdata,
                   reg_we_eff, reg_waddr, reg_wdata};

  // Oldest entry sits count slots behind the write pointer; low bits suffice since
  // count==DEPTH aliases to wr_ptr, which is exactly the oldest slot when full.
  assign rd_addr  = wr_ptr - count[AW-1:0];
  assign rd_data  = mem[rd_addr];
  assign rd_valid = (state == DRAIN) && (count != '0);
  assign busy     = capturing;
  assign done     = (state == DRAIN);

  // Trace storage: no reset, contents only matter once rewritten.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= record;
    end
  end

  // Capture/drain controller: arming, trigger window, fill detection and popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state     <= CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            wrapped   <= 1'b0;
          end
        end
        CAPTURE, POST: begin
          if (do_write) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (count != FULL) begin
              count <= count + CNT_ONE;
            end else if (wrap_mode) begin
              wrapped <= 1'b1;
            end
            if (!wrap_mode) begin
              if (count == LAST) begin
                state <= DRAIN;
              end
            end else if (state == POST) begin
              post_cnt <= post_cnt - PTR_ONE;
              if (post_cnt == PTR_ONE) begin
                state <= DRAIN;
              end
            end else if (trig_hit) begin
              triggered <= 1'b1;
              post_cnt  <= POST_INIT;
              state     <= (POST_TRIG == 0) ? DRAIN : POST;
            end
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state <= IDLE;
          end else if (rd_ready) begin
            count <= count - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: scoreboard bench for mips_trace_buffer (DEPTH=8, POST_TRIG=4).
// A queue-based reference model predicts stored records; a monitor checks every drained record.
// Directed scenarios plus randomized capture sessions with random rd_ready backpressure.
module tb_mips_trace_buffer;

  localparam int DEPTH     = 8;
  localparam int PC_W      = 11;
  localparam int POST_TRIG = 4;
  localparam int REC_W     = PC_W + 32 + 1 + 32 + 32 + 1 + 5 + 32;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PC_W-1:0]   dec_pc;
  logic [31:0]       dec_instr;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              reg_we;
  logic [4:0]        reg_waddr;
  logic [31:0]       reg_wdata;
  logic [1:0]        mode;
  logic              arm;
  logic              abort;
  logic              trig_en;
  logic [PC_W-1:0]   trig_pc;
  logic              rd_valid;
  logic              rd_ready;
  logic [REC_W-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              triggered;
  logic              wrapped;
  logic [CW-1:0]     count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [REC_W-1:0] m_buf[$];
  logic [REC_W-1:0] exp_q[$];
  bit               m_cap;
  bit               m_drain;
  bit               m_trig;
  bit               m_wrap;
  int               m_post;
  bit [1:0]         m_mode;

  mips_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst), .en(en), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mode(mode), .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .triggered(triggered), .wrapped(wrapped), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every presented record must match the oldest expected one; pop on handshake.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_valid_unexpected: got rd_data %h with no record expected", rd_data);
      end else begin
        if (rd_data !== exp_q[0]) begin
          fails++;
          $display("FAIL rd_data: got %h expected %h", rd_data, exp_q[0]);
        end
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic finish_capture();
    m_cap   = 1'b0;
    m_drain = 1'b1;
    foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
  endtask

  task automatic check_status(string tag);
    chk({tag, "_count"}, int'(count), m_buf.size());
    chk({tag, "_busy"}, int'(busy), int'(m_cap));
    chk({tag, "_done"}, int'(done), int'(m_drain));
    chk({tag, "_triggered"}, int'(triggered), int'(m_trig));
    chk({tag, "_wrapped"}, int'(wrapped), int'(m_wrap));
  endtask

  // One CPU cycle of trace input; the model applies the capture rules to it.
  task automatic step(bit e, logic [PC_W-1:0] pc, logic mw, logic rw, logic [4:0] ra);
    logic [REC_W-1:0] r;
    logic rwe;
    bit   qual;
    bit   wrapm;
    en        = e;
    dec_pc    = pc;
    dec_instr = $urandom;
    mem_we    = mw;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    reg_we    = rw;
    reg_waddr = ra;
    reg_wdata = $urandom;
    rwe   = rw && (ra != 5'd0);
    qual  = (m_mode == 2'd2) ? (mw || rwe) : 1'b1;
    wrapm = (m_mode == 2'd0) || (m_mode == 2'd2);
    if (m_cap && e && qual) begin
      r = {pc, dec_instr, mw, mem_addr, mem_wdata, rwe, ra, reg_wdata};
      m_buf.push_back(r);
      if (wrapm && m_buf.size() > DEPTH) begin
        void'(m_buf.pop_front());
        m_wrap = 1'b1;
      end
      if (!wrapm) begin
        if (m_buf.size() == DEPTH) finish_capture();
      end else if (m_post > 0) begin
        m_post--;
        if (m_post == 0) finish_capture();
      end else if (m_post < 0 && trig_en && pc == trig_pc) begin
        m_trig = 1'b1;
        m_post = POST_TRIG;
        if (m_post == 0) finish_capture();
      end
    end
    @(posedge clk); #1;
    check_status("step");
  endtask

  task automatic do_arm(bit [1:0] md);
    mode = md;
    en   = 1'b0;
    arm  = 1'b1;
    @(posedge clk); #1;
    arm    = 1'b0;
    m_mode = md;
    m_cap  = 1'b1;
    m_drain = 1'b0;
    m_buf.delete();
    m_post = -1;
    m_trig = 1'b0;
    m_wrap = 1'b0;
    check_status("arm");
  endtask

  task automatic drain(bit alt);
    int  n = 0;
    bit  ph = 1'b1;
    en = 1'b0;
    while (done === 1'b1 && n < 300) begin
      rd_ready = alt ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      @(posedge clk); #1;
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_timeout", int'(n < 300), 1);
    chk("drain_left_over", exp_q.size(), 0);
    chk("drain_end_count", int'(count), 0);
    chk("drain_end_done", int'(done), 0);
    chk("drain_end_busy", int'(busy), 0);
    m_drain = 1'b0;
    m_buf.delete();
    exp_q.delete();
  endtask

  task automatic abort_cycle(bit with_arm);
    en    = 1'b0;
    abort = 1'b1;
    arm   = with_arm;
    @(posedge clk); #1;
    abort = 1'b0;
    arm   = 1'b0;
    m_cap = 1'b0;
    m_drain = 1'b0;
    m_buf.delete();
    exp_q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cap = 1'b0; m_drain = 1'b0; m_trig = 1'b0; m_wrap = 1'b0;
    m_buf.delete();
    exp_q.delete();
    check_status("reset");
    chk("reset_rd_valid", int'(rd_valid), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; dec_pc = '0; dec_instr = '0; mem_we = 1'b0; mem_addr = '0;
    mem_wdata = '0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0; mode = 2'd0;
    arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    m_cap = 1'b0; m_drain = 1'b0; m_trig = 1'b0; m_wrap = 1'b0; m_post = -1; m_mode = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    do_reset();

    // Stop-on-full: pcs 0..7 fill the buffer, drained with alternating rd_ready
    trig_en = 1'b0;
    do_arm(2'd1);
    for (int p = 0; p < 8; p++) step(1'b1, PC_W'(p), 1'b0, 1'b0, 5'd0);
    drain(1'b1);

    // Wrap + trigger at pc 20: window keeps pcs 17..24
    trig_en = 1'b1; trig_pc = PC_W'(20);
    do_arm(2'd0);
    for (int p = 0; p <= 30; p++) begin
      if (!m_cap) break;
      step(1'b1, PC_W'(p), 1'b0, 1'b0, 5'd0);
    end
    chk("wrap_trig_triggered", int'(triggered), 1);
    chk("wrap_trig_wrapped", int'(wrapped), 1);
    drain(1'b0);

    // Writes-only mode: pc 5 writes $zero and must be skipped
    trig_en = 1'b1; trig_pc = PC_W'(7);
    do_arm(2'd2);
    for (int p = 0; p < 10; p++)
      step(1'b1, PC_W'(p), (p == 3 || p == 7), (p == 5), 5'd0);
    chk("mode2_count", int'(count), 2);
    for (int p = 10; p < 14; p++) step(1'b1, PC_W'(p), 1'b1, 1'b0, 5'd0);
    drain(1'b0);

    // Reset in POST with five records held, then a clean restart
    trig_en = 1'b1; trig_pc = PC_W'(104);
    do_arm(2'd0);
    for (int p = 100; p < 105; p++) step(1'b1, PC_W'(p), 1'b0, 1'b0, 5'd0);
    chk("post_before_reset_count", int'(count), 5);
    do_reset();
    trig_en = 1'b0;
    do_arm(2'd1);
    for (int p = 40; p < 48; p++) step(1'b1, PC_W'(p), 1'b0, 1'b1, 5'd9);
    drain(1'b0);

    // en=0 stall mid-capture, then arm+abort together
    trig_en = 1'b1; trig_pc = PC_W'(2);
    do_arm(2'd1);
    for (int p = 0; p < 3; p++) step(1'b1, PC_W'(p), 1'b0, 1'b0, 5'd0);
    for (int p = 0; p < 3; p++) step(1'b0, PC_W'(2), 1'b1, 1'b1, 5'd3);
    chk("stall_count", int'(count), 3);
    abort_cycle(1'b1);

    // Randomized capture sessions
    for (int s = 0; s < 12; s++) begin
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = PC_W'($urandom_range(0, 15));
      do_arm(2'($urandom_range(0, 3)));
      for (int k = 0; k < 60 && m_cap; k++)
        step($urandom_range(0, 3) != 0, PC_W'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)));
      if (m_cap) abort_cycle(1'b0);
      else drain(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
